// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller:
// FSM states, forwarding selects and the default stall-counter width.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam int unsigned CNT_W_DEF = 16;

  // x0 is hard-wired zero, so a write to it never creates a dependency
  function automatic logic rd_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-stage hazard inputs and the enables/flushes/forwarding
// selects returned by the hazard controller.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = hazard_pkg::CNT_W_DEF
);
  import hazard_pkg::*;

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memrd;
  logic [4:0]       mem_rd;
  logic             mem_regwr;
  logic [4:0]       wb_rd;
  logic             wb_regwr;
  logic             br_taken;
  logic             dmem_req;
  logic             dmem_ack;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             ifid_flush;
  logic             idex_flush;
  fwd_sel_e         fwd_A;
  fwd_sel_e         fwd_B;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_memrd,
           mem_rd, mem_regwr, wb_rd, wb_regwr, br_taken, dmem_req, dmem_ack,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           fwd_A, fwd_B, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_memrd,
           mem_rd, mem_regwr, wb_rd, wb_regwr, br_taken, dmem_req, dmem_ack,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           fwd_A, fwd_B, stall_cycles
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one EX source register; the younger
// MEM-stage result takes priority over WB.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwr,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwr,
  output fwd_sel_e   sel
);

  // Priority select: MEM, then WB, else register file
  always_comb begin
    sel = FWD_RF;
    if (mem_regwr && rd_match(mem_rd, rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwr && rd_match(wb_rd, rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use bubbles, branch
// flushes, data-memory freeze and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic           clk,
  input logic           rst,
  hazard_ctrl_if.slave  hif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  logic             br_pend_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic     freeze_s;
  logic     lu_s;
  logic     pc_en_s;
  logic     ifid_en_s;
  logic     idex_en_s;
  logic     exmem_en_s;
  logic     ifid_flush_s;
  logic     idex_flush_s;
  fwd_sel_e fwd_a_s;
  fwd_sel_e fwd_b_s;

  fwd_sel u_fwd_a (
    .rs        (hif.ex_rs1),
    .mem_rd    (hif.mem_rd),
    .mem_regwr (hif.mem_regwr),
    .wb_rd     (hif.wb_rd),
    .wb_regwr  (hif.wb_regwr),
    .sel       (fwd_a_s)
  );

  fwd_sel u_fwd_b (
    .rs        (hif.ex_rs2),
    .mem_rd    (hif.mem_rd),
    .mem_regwr (hif.mem_regwr),
    .wb_rd     (hif.wb_rd),
    .wb_regwr  (hif.wb_regwr),
    .sel       (fwd_b_s)
  );

  assign freeze_s = hif.dmem_req & ~hif.dmem_ack;
  assign lu_s     = hif.ex_memrd &
                    (rd_match(hif.ex_rd, hif.id_rs1) | rd_match(hif.ex_rd, hif.id_rs2));

  // Same-cycle enable/flush decode from state and current hazards
  always_comb begin
    pc_en_s      = 1'b0;
    ifid_en_s    = 1'b0;
    idex_en_s    = 1'b0;
    exmem_en_s   = 1'b0;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    if (rst) begin
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (freeze_s) begin
            pc_en_s = 1'b0;
          end else if (hif.br_taken) begin
            {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b1111;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (lu_s) begin
            idex_en_s    = 1'b1;
            exmem_en_s   = 1'b1;
            idex_flush_s = 1'b1;
          end else begin
            {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b1111;
          end
        end
        MEM_WAIT: begin
          // Release cycle honours only the branch captured at entry
          if (hif.dmem_ack) begin
            {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b1111;
            ifid_flush_s = br_pend_r;
            idex_flush_s = br_pend_r;
          end else begin
            pc_en_s = 1'b0;
          end
        end
        default: begin
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
        end
      endcase
    end
  end

  // FSM state, pending-branch flag and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      br_pend_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (freeze_s) begin
            state_r   <= MEM_WAIT;
            br_pend_r <= hif.br_taken;
          end else begin
            state_r   <= RUN;
            br_pend_r <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (hif.dmem_ack) begin
            state_r   <= RUN;
            br_pend_r <= 1'b0;
          end else begin
            state_r   <= MEM_WAIT;
            br_pend_r <= br_pend_r;
          end
        end
        default: begin
          state_r   <= RUN;
          br_pend_r <= 1'b0;
        end
      endcase
      if (!pc_en_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign hif.pc_en        = pc_en_s;
  assign hif.ifid_en      = ifid_en_s;
  assign hif.idex_en      = idex_en_s;
  assign hif.exmem_en     = exmem_en_s;
  assign hif.ifid_flush   = ifid_flush_s;
  assign hif.idex_flush   = idex_flush_s;
  assign hif.fwd_A        = rst ? FWD_RF : fwd_a_s;
  assign hif.fwd_B        = rst ? FWD_RF : fwd_b_s;
  assign hif.stall_cycles = stall_cnt_r;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the stall-cycle counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports id_rs1 and id_rs2, input, 5 bits each: source registers of the instruction in ID.
REQ-005 The block SHALL have ports ex_rs1 and ex_rs2, input, 5 bits each: source registers of the instruction in EX.
REQ-006 The block SHALL have ports ex_rd, input, 5 bits, and ex_memrd, input, 1 bit: destination register of the instruction in EX and its load flag.
REQ-007 The block SHALL have ports mem_rd (5 bits) and mem_regwr (1 bit), inputs: destination register and write-enable of the instruction in MEM.
REQ-008 The block SHALL have ports wb_rd (5 bits) and wb_regwr (1 bit), inputs: destination register and write-enable of the instruction in WB.
REQ-009 The block SHALL have port br_taken, input, 1 bit: the branch or jump resolved in EX is taken.
REQ-010 The block SHALL have ports dmem_req and dmem_ack, inputs, 1 bit each: data-memory access in MEM and its completion.
REQ-011 The block SHALL have ports pc_en, ifid_en, idex_en and exmem_en, outputs, 1 bit each: pipeline-register load enables.
REQ-012 The block SHALL have ports ifid_flush and idex_flush, outputs, 1 bit each: insert a bubble into the IF/ID or ID/EX register.
REQ-013 The block SHALL have ports fwd_A and fwd_B, outputs, 2 bits each: EX operand source select, 00 regfile, 01 MEM, 10 WB.
REQ-014 The block SHALL have port stall_cycles, output, CNT_W bits: saturating count of cycles with pc_en=0.

Function
REQ-015 fwd_A SHALL be 01 if mem_regwr is set, mem_rd!=0 and mem_rd==ex_rs1; else 10 if wb_regwr is set, wb_rd!=0 and wb_rd==ex_rs1; else 00.
REQ-016 fwd_B SHALL be selected by the REQ-015 rules applied to ex_rs2, so MEM always beats WB.
REQ-017 Load-use hazard: lu = ex_memrd & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-018 The FSM SHALL have states RUN and MEM_WAIT, plus a 1-bit register br_pend.
REQ-019 Freeze condition: freeze = dmem_req & ~dmem_ack.
REQ-020 In RUN with freeze: all four enables SHALL be 0 and both flushes 0, next state MEM_WAIT, and br_pend SHALL be set to br_taken.
REQ-021 In RUN without freeze and with br_taken: all enables SHALL be 1, ifid_flush=idex_flush=1, and lu is ignored.
REQ-022 In RUN without freeze or br_taken, and with lu: pc_en=ifid_en=0, idex_en=exmem_en=1, idex_flush=1; this is a one-cycle bubble.
REQ-023 In RUN otherwise: all enables SHALL be 1 and both flushes 0.
REQ-024 In RUN, dmem_req and dmem_ack in the same cycle SHALL NOT stall.
REQ-025 In MEM_WAIT with ~dmem_ack: all enables SHALL be 0, both flushes 0, and br_taken and lu are ignored.
REQ-026 In MEM_WAIT with dmem_ack: all enables SHALL be 1, ifid_flush=idex_flush=br_pend, br_pend is cleared, and next state is RUN.
REQ-027 In MEM_WAIT with dmem_ack, lu SHALL be evaluated on the following cycle only, never in the release cycle.
REQ-028 stall_cycles SHALL increment on every cycle with pc_en=0 and hold at 2^CNT_W-1.
REQ-029 fwd_A and fwd_B SHALL remain valid during freeze.

Reset
REQ-030 While rst=1: state=RUN, br_pend=0, stall_cycles=0.
REQ-031 While rst=1: pc_en=ifid_en=idex_en=exmem_en=0, ifid_flush=idex_flush=1, fwd_A=fwd_B=00.
REQ-032 Reset asserted mid-MEM_WAIT SHALL abandon the wait and drop any pending flush; the first cycle after deassertion behaves as RUN.

Structure
REQ-033 Package hazard_pkg SHALL hold the state enum (RUN, MEM_WAIT), the fwd_sel enum (FWD_RF=00, FWD_MEM=01, FWD_WB=10) and the default counter width.
REQ-034 Sub-module fwd_sel SHALL implement REQ-015 for one operand and be instantiated twice, for fwd_A and fwd_B.

Verification
REQ-035 Stimulus ex_rs1=5, mem_rd=5, mem_regwr=1, wb_rd=5, wb_regwr=1 -> required response fwd_A=01; with mem_regwr=0 -> fwd_A=10; with rd=0 everywhere -> fwd_A=00.
REQ-036 Stimulus ex_memrd=1, ex_rd=7, id_rs2=7 -> required response: exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1, and stall_cycles increments by 1.
REQ-037 Stimulus br_taken=1 together with lu=1 -> required response: flushes=1, pc_en=1, stall_cycles unchanged.
REQ-038 Stimulus dmem_req=1 with dmem_ack delayed 3 cycles, br_taken=1 at entry -> required response: 3 frozen cycles, then release cycle with flushes=1, stall_cycles=3.
REQ-039 Stimulus rst pulse during MEM_WAIT with br_pend=1 -> required response: after release, state RUN, no flush, stall_cycles=0.
REQ-040 Stimulus CNT_W=4 and 20 frozen cycles -> required response: stall_cycles saturates at 15.
